serial_ripple_adder: RTL and testbench
======================================

// Module: serial_ripple_adder
// PURPOSE
//  Multi-cycle, parametrised ripple-carry adder built from the full_adder cell.
//  Adds two WIDTH-bit operands DIGIT bits per clock through a DIGIT-long
//  full_adder chain, carrying between steps in a flop. Uses a valid/ready
//  handshake on input and output. Feeds wide-sum and display paths (LEDR/HEX)
//  where one wide combinational chain is too slow.
// PARAMETERS
//  WIDTH  8  operand and sum width in bits; must be >= 1
//  DIGIT  2  bits added per cycle; must divide WIDTH exactly (compile-time check)
// PORTS
//  clock      in   1      single clock; all state changes on the rising edge
//  reset      in   1      synchronous reset, active-high
//  in_valid   in   1      operands a, b and cin are valid
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum, cout and overflow are valid (high only in DONE)
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  registered sum
//  cout       out  1      carry out of the MSB
//  overflow   out  1      two's-complement overflow (carry into MSB ^ cout)
//  busy       out  1      high in BUSY
// BEHAVIOUR
//  - Reset state is IDLE: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0.
//  - reset has priority over every other input on any cycle. It returns the
//    block to IDLE mid-operation and discards partial results.
//  - NSTEP = WIDTH/DIGIT.
//  - IDLE: in_ready=1. On in_valid & in_ready: latch a and b, set carry=cin,
//    clear step count, go to BUSY. in_valid without in_ready is ignored, not queued.
//  - BUSY: each cycle add the low DIGIT bits of the A and B shift registers plus
//    carry. Shift the DIGIT result bits into sum from the MSB end, update carry,
//    and record the carry into the MSB on the final step. After NSTEP cycles go to DONE.
//  - DONE: out_valid=1. sum, cout and overflow are stable until out_ready. On
//    out_valid & out_ready go to IDLE; in_ready rises on the following cycle.
//    There is no overlap of consecutive operations.
//  - Latency: accept at edge k gives out_valid high after edge k+NSTEP.
//    Throughput is one result per NSTEP+2 cycles with out_ready held high.
//  - Arithmetic is modulo 2^WIDTH, and cout is the true bit WIDTH.
//  - sum, cout and overflow keep their last result through IDLE. They are
//    not cleared on a new accept until overwritten.
//  - DIGIT==WIDTH is legal: a single BUSY cycle.
//  - WIDTH==1 is legal; overflow then equals cin_into_msb ^ cout.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//  - Adds input port sub (1 bit), sampled with the operands.
//  - When sub=1 the block latches ~b and forces the initial carry to 1,
//    ignoring cin. Result = a - b; cout=1 means no borrow.
//  - overflow then flags signed subtraction overflow.
//  SERIAL_ADDER_SUB_EN undefined:
//  - Port sub is absent and the block only adds.
// TESTING
//  T1 WIDTH=8 DIGIT=2: a=0x3C b=0x45 cin=0 -> out_valid after 4 cycles;
//     sum=0x81 cout=0 overflow=1.
//  T2 a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 overflow=0.
//     Then a=0xFF b=0x00 cin=1 -> sum=0x00 cout=1 overflow=0.
//  T3 backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/overflow
//     stable, in_ready=0. A second in_valid is ignored; one result per accept.
//  T4 reset asserted on BUSY step 2 -> next cycle IDLE, in_ready=1, out_valid=0,
//     all outputs 0. A fresh 0x10+0x20 then yields 0x30.
//  T5 SERIAL_ADDER_SUB_EN, sub=1: a=0x05 b=0x07 -> sum=0xFE cout=0 overflow=0.
//     a=0x80 b=0x01 -> sum=0x7F cout=1 overflow=1.
//  T6 WIDTH=16 DIGIT=16: a=0xFFFF b=0x0001 -> sum=0x0000 cout=1,
//     out_valid one cycle after accept. Random compare vs a+b+cin, 1000 vectors.

Source files
------------

// File: rtl/serial_ripple_adder_if.sv
// Handshake and operand/result bundle for serial_ripple_adder.
// Carries the 'sub' select only when SERIAL_ADDER_SUB_EN is defined.
interface serial_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output in_ready, out_valid, sum, cout, overflow, busy
  );
endinterface

// File: rtl/serial_ripple_adder.sv
// Multi-cycle ripple-carry adder: DIGIT bits per clock through a full_adder chain.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' select (a - b via ~b and carry-in 1).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high, last result held
// BUSY  | adding one DIGIT-wide slice per cycle
// DONE  | result presented with out_valid until out_ready
module serial_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clock,
  input  logic               reset,
  serial_ripple_adder_if.slave bus
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_ripple_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    step_q;
  logic             in_ready_c, out_valid_c, busy_c;
  logic             accept, last_step;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  logic [DIGIT:0]         chain;
  logic [DIGIT-1:0]       dsum;
  logic [WIDTH+DIGIT-1:0] sum_cat;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  assign chain[0] = carry_q;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      full_adder u_fa (
        .a  (a_sh[gi]),
        .b  (b_sh[gi]),
        .ci (chain[gi]),
        .s  (dsum[gi]),
        .co (chain[gi+1])
      );
    end
  endgenerate

  // New digits enter at the MSB end; after NSTEP shifts the sum is aligned.
  assign sum_cat   = {dsum, sum_q};
  assign last_step = (step_q == LAST);
  assign accept    = bus.in_valid && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy_c = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh    <= bus.a;
        b_sh    <= b_load;
        carry_q <= c_load;
        step_q  <= '0;
      end else if (state_q == S_BUSY) begin
        a_sh    <= a_sh >> DIGIT;
        b_sh    <= b_sh >> DIGIT;
        sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
        carry_q <= chain[DIGIT];
        step_q  <= step_q + 1'b1;
        if (last_step) begin
          cout_q <= chain[DIGIT];
          ovf_q  <= chain[DIGIT] ^ chain[DIGIT-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_serial_ripple_adder.sv
// Bench for serial_ripple_adder: an 8-bit/2-digit instance and a 16-bit/16-digit instance
// checked against an arithmetic reference model with randomized operands.
module tb_serial_ripple_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  serial_ripple_adder_if #(.WIDTH(8))  if8 ();
  serial_ripple_adder_if #(.WIDTH(16)) if16 ();

  serial_ripple_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clock (clk),
    .reset (rst8),
    .bus   (if8.slave)
  );

  serial_ripple_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clock (clk),
    .reset (rst16),
    .bus   (if16.slave)
  );

  // Returns {overflow, cout, sum[15:0]} for a w-bit add (or subtract when s=1).
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s);
    logic [16:0] mask, xx, yy, full, sm;
    logic        cc, ov, co;
    mask = (17'd1 << w) - 17'd1;
    xx   = {1'b0, x} & mask;
    yy   = s ? (~{1'b0, y}) & mask : {1'b0, y} & mask;
    cc   = s ? 1'b1 : c;
    full = xx + yy + {16'd0, cc};
    sm   = full & mask;
    co   = full[w];
    ov   = (xx[w-1] == yy[w-1]) && (sm[w-1] != xx[w-1]);
    return {ov, co, sm[15:0]};
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input int hold,
                     output logic [9:0] res, output int lat);
    int n;
    n = 0;
    while (!if8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if8.a = ta; if8.b = tb_v; if8.cin = tc; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    repeat (hold) begin @(posedge clk); #1; end
    res = {if8.overflow, if8.cout, if8.sum};
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      output logic [17:0] res, output int lat);
    int n;
    n = 0;
    while (!if16.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if16.a = ta; if16.b = tb_v; if16.cin = tc; if16.in_valid = 1'b1;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    res = {if16.overflow, if16.cout, if16.sum};
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout, if8.overflow} !== {3'b100, 8'h00, 2'b00})
      $display("FAIL reset8: got rdy=%b vld=%b busy=%b sum=%h c=%b ov=%b, want rdy=1 vld=0 busy=0 sum=00 c=0 ov=0",
               if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout, if8.overflow);
    else pass_cnt++;
    chk_cnt++;
    if ({if16.in_ready, if16.out_valid, if16.busy, if16.sum, if16.cout, if16.overflow} !== {3'b100, 16'h0, 2'b00})
      $display("FAIL reset16: got rdy=%b vld=%b busy=%b sum=%h, want rdy=1 vld=0 busy=0 sum=0000",
               if16.in_ready, if16.out_valid, if16.busy, if16.sum);
    else pass_cnt++;
    rst8 = 1'b0; rst16 = 1'b0;
  endtask

  task automatic test_directed();
    logic [9:0] r;
    int lat;
    op8(8'h3C, 8'h45, 1'b0, 0, r, lat);
    chk_cnt++;
    if (lat !== 4) $display("FAIL t1_latency: got %0d want 4", lat); else pass_cnt++;
    chk_cnt++;
    if (r !== {1'b1, 1'b0, 8'h81}) $display("FAIL t1_result: got ov/c/sum=%b/%b/%h want 1/0/81", r[9], r[8], r[7:0]);
    else pass_cnt++;
    op8(8'hFF, 8'h01, 1'b0, 0, r, lat);
    chk_cnt++;
    if (r !== {1'b0, 1'b1, 8'h00}) $display("FAIL t2a_result: got ov/c/sum=%b/%b/%h want 0/1/00", r[9], r[8], r[7:0]);
    else pass_cnt++;
    op8(8'hFF, 8'h00, 1'b1, 0, r, lat);
    chk_cnt++;
    if (r !== {1'b0, 1'b1, 8'h00}) $display("FAIL t2b_result: got ov/c/sum=%b/%b/%h want 0/1/00", r[9], r[8], r[7:0]);
    else pass_cnt++;
    chk_cnt++;
    if ({if8.in_ready, if8.out_valid} !== 2'b10)
      $display("FAIL after_handshake: got rdy=%b vld=%b want rdy=1 vld=0", if8.in_ready, if8.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b1; if8.in_valid = 1'b1;
    e = model(8, 16'h005A, 16'h0033, 1'b1, 1'b0);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if ({if8.busy, if8.in_ready, if8.out_valid} !== 3'b100)
        $display("FAIL busy_step%0d: got busy=%b rdy=%b vld=%b want 1/0/0", i, if8.busy, if8.in_ready, if8.out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if ({if8.out_valid, if8.busy} !== 2'b10)
      $display("FAIL done_entry: got vld=%b busy=%b want 1/0", if8.out_valid, if8.busy);
    else pass_cnt++;
    if8.a = 8'h01; if8.b = 8'h01; if8.cin = 1'b0; if8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++;
      if ({if8.overflow, if8.cout, if8.sum, if8.in_ready, if8.out_valid} !== {e[17:16], e[7:0], 2'b01})
        $display("FAIL stall%0d: got ov/c/sum=%b/%b/%h rdy=%b vld=%b want %b/%b/%h rdy=0 vld=1",
                 i, if8.overflow, if8.cout, if8.sum, if8.in_ready, if8.out_valid, e[17], e[16], e[7:0]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_cnt++;
      if ({if8.out_valid, if8.busy, if8.in_ready} !== 3'b001)
        $display("FAIL no_second_result%0d: got vld=%b busy=%b rdy=%b want 0/0/1", i, if8.out_valid, if8.busy, if8.in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    logic [9:0] r;
    int lat;
    if8.a = 8'h77; if8.b = 8'h11; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk_cnt++;
    if ({if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout, if8.overflow} !== {3'b100, 8'h00, 2'b00})
      $display("FAIL midop_reset: got rdy=%b vld=%b busy=%b sum=%h c=%b ov=%b want 1/0/0/00/0/0",
               if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout, if8.overflow);
    else pass_cnt++;
    op8(8'h10, 8'h20, 1'b0, 0, r, lat);
    chk_cnt++;
    if (r !== {2'b00, 8'h30}) $display("FAIL after_reset_add: got ov/c/sum=%b/%b/%h want 0/0/30", r[9], r[8], r[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    logic [17:0] e;
    int last_acc, accepts;
    last_acc = -1;
    accepts  = 0;
    if8.out_ready = 1'b1;
    if8.in_valid  = 1'b1;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc == 40) if8.in_valid = 1'b0;
      if (if8.out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        chk_cnt++;
        if ({if8.overflow, if8.cout, if8.sum} !== {e[17:16], e[7:0]})
          $display("FAIL b2b_result: got ov/c/sum=%b/%b/%h want %b/%b/%h",
                   if8.overflow, if8.cout, if8.sum, e[17], e[16], e[7:0]);
        else pass_cnt++;
      end
      if (if8.in_valid && if8.in_ready) begin
        q.push_back(model(8, {8'h00, if8.a}, {8'h00, if8.b}, if8.cin, 1'b0));
        if (last_acc >= 0) begin
          chk_cnt++;
          if (cyc - last_acc !== 6) $display("FAIL b2b_gap: got %0d cycles want 6", cyc - last_acc);
          else pass_cnt++;
        end
        last_acc = cyc;
        accepts++;
      end else if (!if8.in_ready) begin
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    if8.out_ready = 1'b0;
    chk_cnt++;
    if (q.size() !== 0 || accepts < 5)
      $display("FAIL b2b_drain: got %0d pending of %0d accepts want 0 pending", q.size(), accepts);
    else pass_cnt++;
  endtask

  task automatic test_random8();
    logic [9:0]  r;
    logic [17:0] e;
    logic [7:0]  x, y;
    logic        c, s;
    int lat;
    for (int i = 0; i < 200; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = 1'($urandom);
      if8.sub = s;
`endif
      e = model(8, {8'h00, x}, {8'h00, y}, c, s);
      op8(x, y, c, $urandom_range(0, 3), r, lat);
      chk_cnt++;
      if (r !== {e[17:16], e[7:0]} || lat !== 4)
        $display("FAIL rand8 a=%h b=%h cin=%b sub=%b: got ov/c/sum=%b/%b/%h lat=%0d want %b/%b/%h lat=4",
                 x, y, c, s, r[9], r[8], r[7:0], lat, e[17], e[16], e[7:0]);
      else pass_cnt++;
    end
`ifdef SERIAL_ADDER_SUB_EN
    if8.sub = 1'b0;
`endif
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [9:0] r;
    int lat;
    if8.sub = 1'b1;
    op8(8'h05, 8'h07, 1'b0, 0, r, lat);
    chk_cnt++;
    if (r !== {2'b00, 8'hFE}) $display("FAIL sub_5_7: got ov/c/sum=%b/%b/%h want 0/0/fe", r[9], r[8], r[7:0]);
    else pass_cnt++;
    op8(8'h80, 8'h01, 1'b0, 0, r, lat);
    chk_cnt++;
    if (r !== {2'b11, 8'h7F}) $display("FAIL sub_80_1: got ov/c/sum=%b/%b/%h want 1/1/7f", r[9], r[8], r[7:0]);
    else pass_cnt++;
    if8.sub = 1'b0;
  endtask
`endif

  task automatic test_wide();
    logic [17:0] r, e;
    logic [15:0] x, y;
    logic        c;
    int lat, bad;
    op16(16'hFFFF, 16'h0001, 1'b0, r, lat);
    chk_cnt++;
    if (r[16:0] !== {1'b1, 16'h0000} || lat !== 1)
      $display("FAIL wide_ffff_1: got c/sum=%b/%h lat=%0d want 1/0000 lat=1", r[16], r[15:0], lat);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      e = model(16, x, y, c, 1'b0);
      op16(x, y, c, r, lat);
      chk_cnt++;
      if (r !== e || lat !== 1) begin
        if (bad < 10)
          $display("FAIL rand16 a=%h b=%h cin=%b: got ov/c/sum=%b/%b/%h lat=%0d want %b/%b/%h lat=1",
                   x, y, c, r[17], r[16], r[15:0], lat, e[17], e[16], e[15:0]);
        bad++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    if8.sub = 1'b0; if16.sub = 1'b0;
`endif
    rst8 = 1'b1; rst16 = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random8();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end
endmodule
